// File: rtl/bitop_stream_reducer_if.sv
// rtl/bitop_stream_reducer_if.sv - input beat / output result handshake bundle for bitop_stream_reducer
// out_popcnt exists only when BITOP_STREAM_POPCOUNT_EN is defined.
interface bitop_stream_reducer_if #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 2,
    parameter int MAX_BEATS = 16
);
    logic                             in_valid;
    logic                             in_ready;
    logic [LANES*WIDTH-1:0]           in_data;
    logic [1:0]                       in_op;
    logic                             in_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [WIDTH-1:0]                 out_data;
    logic [$clog2(MAX_BEATS+1)-1:0]   out_beats;
    logic                             out_err;
`ifdef BITOP_STREAM_POPCOUNT_EN
    logic [$clog2(WIDTH+1)-1:0]       out_popcnt;
`endif

    modport slave (
`ifdef BITOP_STREAM_POPCOUNT_EN
        output out_popcnt,
`endif
        input  in_valid, in_data, in_op, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_err
    );

    modport master (
`ifdef BITOP_STREAM_POPCOUNT_EN
        input  out_popcnt,
`endif
        output in_valid, in_data, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_err
    );
endinterface

// File: rtl/bitop_stream_reducer.sv
// rtl/bitop_stream_reducer.sv - folds a packet of multi-lane beats into one word with AND/OR/XOR/XNOR
// Optional BITOP_STREAM_POPCOUNT_EN adds a registered population count of the result.
module bitop_stream_reducer #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 2,
    parameter int MAX_BEATS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    bitop_stream_reducer_if.slave  bus
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam int PW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              drain_q, drain_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]     out_beats_q, out_beats_d;
    logic              out_err_q, out_err_d;
`ifdef BITOP_STREAM_POPCOUNT_EN
    logic [PW-1:0]     popcnt_q, popcnt_d;
`endif

    logic [WIDTH-1:0]  lane_val;
    logic [WIDTH-1:0]  acc_new;
    logic [CW-1:0]     cnt_new;
    logic [1:0]        op_new;
    logic              go_out;
    logic              err_new;

    // XNOR folds as XOR; the inversion happens once when the result is latched.
    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       op);
        case (op)
            OP_AND:  combine = a & b;
            OP_OR:   combine = a | b;
            default: combine = a ^ b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] lane_reduce(input logic [LANES*WIDTH-1:0] d,
                                                     input logic [1:0]             op);
        logic [WIDTH-1:0] r;
        r = d[WIDTH-1:0];
        for (int k = 1; k < LANES; k++) begin
            r = combine(r, d[k*WIDTH +: WIDTH], op);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_err_d   = out_err_q;
        acc_new     = acc_q;
        cnt_new     = cnt_q;
        op_new      = op_q;
        go_out      = 1'b0;
        err_new     = 1'b0;
        lane_val    = lane_reduce(bus.in_data, (state_q == S_IDLE) ? bus.in_op : op_q);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_new  = bus.in_op;
                    acc_new = lane_val;
                    cnt_new = CW'(1);
                    if (bus.in_last) begin
                        go_out = 1'b1;
                    end else if (cnt_new == CW'(MAX_BEATS)) begin
                        go_out  = 1'b1;
                        err_new = 1'b1;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (bus.in_valid) begin
                    acc_new = combine(acc_q, lane_val, op_q);
                    cnt_new = cnt_q + CW'(1);
                    if (bus.in_last) begin
                        go_out = 1'b1;
                    end else if (cnt_new == CW'(MAX_BEATS)) begin
                        go_out  = 1'b1;
                        err_new = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = drain_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.in_valid && bus.in_last) begin
                    state_d = S_IDLE;
                    drain_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        acc_d = acc_new;
        cnt_d = cnt_new;
        op_d  = op_new;
        if (go_out) begin
            state_d     = S_OUT;
            drain_d     = err_new;
            out_data_d  = (op_new == OP_XNOR) ? ~acc_new : acc_new;
            out_beats_d = cnt_new;
            out_err_d   = err_new;
        end
    end

`ifdef BITOP_STREAM_POPCOUNT_EN
    always_comb begin
        popcnt_d = popcnt_q;
        if (go_out) begin
            popcnt_d = popcount(out_data_d);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= OP_AND;
            drain_q     <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_err_q   <= 1'b0;
`ifdef BITOP_STREAM_POPCOUNT_EN
            popcnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            drain_q     <= drain_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_err_q   <= out_err_d;
`ifdef BITOP_STREAM_POPCOUNT_EN
            popcnt_q    <= popcnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q != S_OUT);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_err   = out_err_q;
`ifdef BITOP_STREAM_POPCOUNT_EN
    assign bus.out_popcnt = popcnt_q;
`endif
endmodule

// File: tb/tb_bitop_stream_reducer.sv
// tb/tb_bitop_stream_reducer.sv - directed-vector bench for bitop_stream_reducer (MAX_BEATS=4 build)
module tb_bitop_stream_reducer;
    localparam int WIDTH     = 32;
    localparam int LANES     = 2;
    localparam int MAX_BEATS = 4;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    bitop_stream_reducer_if #(.WIDTH(WIDTH), .LANES(LANES), .MAX_BEATS(MAX_BEATS)) bus ();

    bitop_stream_reducer #(.WIDTH(WIDTH), .LANES(LANES), .MAX_BEATS(MAX_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat for a single cycle; returns at the following negedge.
    task automatic beat(input logic [31:0] l0, input logic [31:0] l1,
                        input logic [1:0] op, input logic last);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = {l1, l0};
        bus.in_op    = op;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] data,
                                 input int beats, input logic err);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_rdy"},   64'(bus.in_ready),  64'd0);
        check({tag, "_data"},  64'(bus.out_data),  64'(data));
        check({tag, "_beats"}, 64'(bus.out_beats), 64'(beats));
        check({tag, "_err"},   64'(bus.out_err),   64'(err));
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_taken"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_op     = OP_AND;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_rdy",   64'(bus.in_ready),  64'd1);
        check("rst_data",  64'(bus.out_data),  64'd0);
        check("rst_beats", 64'(bus.out_beats), 64'd0);
        check("rst_err",   64'(bus.out_err),   64'd0);
        rst = 1'b0;

        beat(32'hFFFF_0000, 32'h0F0F_0F0F, OP_AND, 1'b1);
        expect_result("and1", 32'h0F0F_0000, 1, 1'b0);
`ifdef BITOP_STREAM_POPCOUNT_EN
        check("and1_pop", 64'(bus.out_popcnt), 64'd8);
`endif
        take("and1");

        beat(32'h1, 32'h2, OP_XOR, 1'b0);
        beat(32'h4, 32'h0, OP_AND, 1'b0);
        check("xor3_midvalid", 64'(bus.out_valid), 64'd0);
        beat(32'h1, 32'h0, OP_XOR, 1'b1);
        expect_result("xor3", 32'h0000_0006, 3, 1'b0);
        take("xor3");

        beat(32'h0, 32'h0, OP_XNOR, 1'b1);
        expect_result("xnor1", 32'hFFFF_FFFF, 1, 1'b0);
`ifdef BITOP_STREAM_POPCOUNT_EN
        check("xnor1_pop", 64'(bus.out_popcnt), 64'd32);
`endif
        take("xnor1");

        beat(32'h8000_0000, 32'h1, OP_OR, 1'b1);
        expect_result("or1", 32'h8000_0001, 1, 1'b0);
        take("or1");

        // Six-beat OR packet overruns MAX_BEATS=4.
        beat(32'h1, 32'h0, OP_OR, 1'b0);
        beat(32'h2, 32'h0, OP_OR, 1'b0);
        beat(32'h4, 32'h0, OP_OR, 1'b0);
        beat(32'h8, 32'h0, OP_OR, 1'b0);
        expect_result("ovf", 32'h0000_000F, 4, 1'b1);

        bus.in_valid = 1'b1;
        bus.in_data  = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rdy",  64'(bus.in_ready),  64'd0);
            check("stall_data", 64'(bus.out_data),  64'h0000_000F);
            check("stall_vld",  64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        check("stall_beats", 64'(bus.out_beats), 64'd4);
        take("ovf");

        beat(32'h100, 32'h0, OP_OR, 1'b0);
        check("drain5_valid", 64'(bus.out_valid), 64'd0);
        check("drain5_rdy",   64'(bus.in_ready),  64'd1);
        beat(32'h200, 32'h0, OP_OR, 1'b1);
        check("drain6_valid", 64'(bus.out_valid), 64'd0);

        beat(32'hFFFF_FFFF, 32'h0000_FFFF, OP_AND, 1'b1);
        expect_result("post", 32'h0000_FFFF, 1, 1'b0);
        take("post");

        // Asynchronous reset in the middle of an accumulating packet.
        beat(32'hAAAA_0000, 32'h0, OP_OR, 1'b0);
        beat(32'h0000_5555, 32'h0, OP_OR, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_rdy",   64'(bus.in_ready),  64'd1);
        check("arst_data",  64'(bus.out_data),  64'd0);
        check("arst_beats", 64'(bus.out_beats), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("arst_hold", 64'(bus.out_valid), 64'd0);

        beat(32'h3, 32'h5, OP_XOR, 1'b1);
        expect_result("after_rst", 32'h0000_0006, 1, 1'b0);
        take("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bitop_stream_reducer.md
Name: bitop_stream_reducer

Overview:
- Parametrised successor to the team's single-cycle registered 32-bit AND stage.
- Reduces a packet of multi-lane beats into one WIDTH-bit word using a selectable bitwise operation (AND/OR/XOR/XNOR).
- Uses valid/ready handshakes on input and output.
- Sits between DFI-side data capture and the controller's status/compare logic, e.g. mask merging and read-data compare folding.

Parameters:
WIDTH, 32, bits per lane and per result
LANES, 2, operands per input beat (>=1)
MAX_BEATS, 16, maximum beats per packet before forced termination (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  LANES*WIDTH  lane k = in_data[k*WIDTH +: WIDTH]
in_op  in  2  00 AND, 01 OR, 10 XOR, 11 XNOR; sampled on first beat of packet only
in_last  in  1  final beat of packet
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_data  out  WIDTH  reduced result
out_beats  out  $clog2(MAX_BEATS+1)  beats folded into result
out_err  out  1  packet exceeded MAX_BEATS (forced termination)

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
- Reset values: state IDLE; out_valid=0; out_data=0; out_beats=0; out_err=0; in_ready=1; accumulator=0; latched op=AND.
- Lane reduce (combinational): AND/OR/XOR of all LANES lanes. XNOR uses XOR here; the final inversion is applied only at output.
- States: IDLE, ACC, OUT, DRAIN.
- IDLE (in_ready=1):
  - On an accepted beat: latch in_op; acc = lane reduce; count = 1.
  - If in_last -> OUT.
  - Else if count==MAX_BEATS -> OUT with err, drain pending.
  - Else -> ACC.
- ACC (in_ready=1):
  - On an accepted beat: acc = acc op lane-reduce (XNOR packets use XOR); count++; in_op ignored.
  - in_last -> OUT with err=0.
  - count reaching MAX_BEATS without in_last -> OUT with err=1 and drain-pending flag set.
- OUT (in_ready=0, out_valid=1):
  - out_data = acc (inverted when latched op is XNOR); out_beats = count; out_err per above.
  - Outputs stay stable until handshake.
  - On handshake: out_valid=0; go to DRAIN if drain pending, else IDLE.
- DRAIN (in_ready=1, out_valid=0):
  - Accepted beats are discarded.
  - Beat with in_last -> IDLE and clear drain flag.
- Latency: out_valid asserts the cycle after the last beat is accepted.
- Throughput: one packet per (beats + 1 + output stall) cycles.
- Boundary conditions:
  - MAX_BEATS=1: every beat without last produces err=1 then drains.
  - Single-beat packet with in_last: out_beats=1.
  - LANES=1: lane reduce is identity.
  - in_valid low in ACC: hold state, no counting.
  - out_ready held high in OUT: one-cycle OUT.
- Reset mid-packet or in OUT: result is lost, all state returns to reset values asynchronously, no output emitted.
- No combinational path from out_ready to in_ready beyond the registered state.

Optional Feature:
- Macro: BITOP_STREAM_POPCOUNT_EN
- Defined:
  - Adds output port out_popcnt [$clog2(WIDTH+1)] = number of 1s in out_data.
  - Registered on OUT entry, valid with out_valid, reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=32, LANES=2: op AND, single beat lanes 0xFFFF0000/0x0F0F0F0F, last=1 -> next cycle out_valid=1, out_data=0x0F0F0000, out_beats=1, out_err=0.
- op XOR, 3 beats (lanes 0x1/0x2, 0x4/0x0, 0x1/0x0, last on third); in_op changed to AND on beat 2 -> out_data=0x00000006, out_beats=3 (op change ignored).
- op XNOR, one beat 0x0/0x0 last -> out_data=0xFFFFFFFF; op OR, beat 0x8000_0000/0x1 -> 0x80000001.
- MAX_BEATS=4, OR packet of 6 beats (last on 6th) -> result after beat 4 with out_beats=4, out_err=1; beats 5-6 accepted and discarded; next packet processes normally.
- out_ready held low 5 cycles in OUT -> out_data stable, in_ready=0, no beats accepted; rst pulse mid-ACC -> out_valid=0, in_ready=1, out_data=0.
- With BITOP_STREAM_POPCOUNT_EN: AND result 0x0F0F0000 -> out_popcnt=8; without the macro, compile succeeds with no out_popcnt port.
